// File: rtl/accel_sample_filter.sv
// Decimating moving-average filter with output dead-zone for 9-bit accelerometer X/Y samples.
// Two-stage pipeline: capture into the ring buffer on the tick edge, then publish outputs one edge later.
module accel_sample_filter #(
    parameter int DATA_W     = 9,
    parameter int AVG_LOG2   = 3,
    parameter int SAMPLE_DIV = 50000,
    parameter int DEADZONE   = 2,
    parameter int RESET_VAL  = 256
) (
    input  logic              clock,
    input  logic              anti_reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] accel_x_in,
    input  logic [DATA_W-1:0] accel_y_in,
    output logic [31:0]       filt_x_out,
    output logic [31:0]       filt_y_out,
    output logic              sample_valid,
    output logic              buffer_full
);

    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int SUM_W  = DATA_W + AVG_LOG2;
    localparam int CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int FILL_W = AVG_LOG2 + 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);
    localparam logic [DATA_W-1:0] OUT_RST  = DATA_W'(RESET_VAL);
    localparam logic [DATA_W:0]   DZ_LIM   = (DATA_W + 1)'(DEADZONE);

    typedef enum logic {
        S_FILL,
        S_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [SUM_W-1:0]    sum_x_q, sum_x_d;
    logic [SUM_W-1:0]    sum_y_q, sum_y_d;
    logic [DATA_W-1:0]   buf_x_q [DEPTH];
    logic [DATA_W-1:0]   buf_x_d [DEPTH];
    logic [DATA_W-1:0]   buf_y_q [DEPTH];
    logic [DATA_W-1:0]   buf_y_d [DEPTH];
    logic [DATA_W-1:0]   raw_x_q, raw_x_d;
    logic [DATA_W-1:0]   raw_y_q, raw_y_d;
    logic [DATA_W-1:0]   out_x_q, out_x_d;
    logic [DATA_W-1:0]   out_y_q, out_y_d;
    logic                stage1_q, stage1_d;
    logic                valid_q, valid_d;
    logic                tick;

    // Returns the new average only when it has moved more than the dead-zone away from the held value.
    function automatic logic [DATA_W-1:0] dead_zone(input logic [SUM_W-1:0]  sum,
                                                     input logic [DATA_W-1:0] held);
        logic [DATA_W-1:0] avg;
        logic [DATA_W:0]   diff;
        avg  = sum[SUM_W-1:AVG_LOG2];
        diff = (avg >= held) ? ({1'b0, avg} - {1'b0, held})
                             : ({1'b0, held} - {1'b0, avg});
        return (diff > DZ_LIM) ? avg : held;
    endfunction

    assign tick = enable && (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        sum_x_d  = sum_x_q;
        sum_y_d  = sum_y_q;
        buf_x_d  = buf_x_q;
        buf_y_d  = buf_y_q;
        raw_x_d  = raw_x_q;
        raw_y_d  = raw_y_q;
        out_x_d  = out_x_q;
        out_y_d  = out_y_q;
        stage1_d = 1'b0;
        valid_d  = 1'b0;

        if (!enable) begin
            // Disabled: flush the window and drop any sample in flight; outputs keep their value.
            state_d  = S_FILL;
            cnt_d    = '0;
            wr_ptr_d = '0;
            fill_d   = '0;
            sum_x_d  = '0;
            sum_y_d  = '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_x_d[i] = '0;
                buf_y_d[i] = '0;
            end
        end else begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;

            if (tick) begin
                buf_x_d[wr_ptr_q] = accel_x_in;
                buf_y_d[wr_ptr_q] = accel_y_in;
                sum_x_d  = sum_x_q - SUM_W'(buf_x_q[wr_ptr_q]) + SUM_W'(accel_x_in);
                sum_y_d  = sum_y_q - SUM_W'(buf_y_q[wr_ptr_q]) + SUM_W'(accel_y_in);
                wr_ptr_d = wr_ptr_q + 1'b1;
                raw_x_d  = accel_x_in;
                raw_y_d  = accel_y_in;
                stage1_d = 1'b1;
                if (fill_q < FILL_MAX) begin
                    fill_d = fill_q + 1'b1;
                end
                if (fill_d == FILL_MAX) begin
                    state_d = S_RUN;
                end
            end

            if (stage1_q) begin
                valid_d = 1'b1;
                if (state_q == S_FILL) begin
                    out_x_d = raw_x_q;
                    out_y_d = raw_y_q;
                end else begin
                    out_x_d = dead_zone(sum_x_q, out_x_q);
                    out_y_d = dead_zone(sum_y_q, out_y_q);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge anti_reset) begin
        if (!anti_reset) begin
            state_q  <= S_FILL;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            sum_x_q  <= '0;
            sum_y_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_x_q[i] <= '0;
                buf_y_q[i] <= '0;
            end
            raw_x_q  <= '0;
            raw_y_q  <= '0;
            out_x_q  <= OUT_RST;
            out_y_q  <= OUT_RST;
            stage1_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            sum_x_q  <= sum_x_d;
            sum_y_q  <= sum_y_d;
            buf_x_q  <= buf_x_d;
            buf_y_q  <= buf_y_d;
            raw_x_q  <= raw_x_d;
            raw_y_q  <= raw_y_d;
            out_x_q  <= out_x_d;
            out_y_q  <= out_y_d;
            stage1_q <= stage1_d;
            valid_q  <= valid_d;
        end
    end

    assign filt_x_out   = 32'(out_x_q);
    assign filt_y_out   = 32'(out_y_q);
    assign sample_valid = valid_q;
    assign buffer_full  = (state_q == S_RUN);

endmodule
